cube_session_ctrl: RTL and testbench
====================================

Name: cube_session_ctrl

Overview:
Parametrised successor to the cube driver FSM. Owns the cube state register and sequences start, scramble, manual move, undo and redo, with solved detection and a saturating move counter. The external combinational move engine computes each move. History holds compact move codes in a wrap-around ring, not full cube states; undo applies the inverse move.

Parameters:
STATE_W, 162, cube state width (54 stickers x 3 bits)
HIST_DEPTH, 64, ring entries (power of 2)
SCRAMBLE_LEN, 20, random moves per scramble (>=1)
CNT_W, 10, move counter width
CNT_MAX, 999, counter saturation value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
scramble_req  in  1  one-cycle pulse
move_req  in  1  one-cycle pulse
undo_req  in  1  one-cycle pulse
redo_req  in  1  one-cycle pulse (used only with CUBE_REDO_EN)
face_sel  in  3  manual face 0..5
rot_sel  in  2  manual rotation: 0 none, 1 CW, 2 double, 3 CCW
rand_face  in  3  generator face
rand_rot  in  2  generator rotation: 0->CW, 1->CCW, 2->double, 3->CW
eng_face  out  3  face presented to move engine
eng_rot  out  3  quarter-turn count 0..3 presented to engine
eng_state_in  in  STATE_W  engine result for cube_state
cube_state  out  STATE_W  current cube
move_count  out  CNT_W  user move count
hist_level  out  $clog2(HIST_DEPTH)+1  valid undo entries
busy  out  1  high outside IDLE/DONE
solved  out  1  high in DONE
fsm_state  out  3  state code (LED debug)

Behaviour:
- Reset: FSM=START, cube_state=0, move_count=0, hist_level=0, wr_ptr=0, redo_level=0, scrambled=0, solved=0, busy=1.
- Encodings: START=0, IDLE=1, SCRAMBLE=2, APPLY=3, UNDO=4, REDO=5, DONE=6.
- START (1 cycle): load solved pattern (face f on stickers 9f..9f+8 = f); clear counters, history and scrambled; go to IDLE.
- IDLE: requests are sampled only here. Priority: scramble > move > undo > redo. Requests arriving in any other state are dropped.
- Solved check in IDLE: with no request pending, cube_state==solved pattern && (move_count!=0 || scrambled) -> DONE.
- SCRAMBLE: cube_state<=eng_state_in once per cycle using rand_face/rand_rot, for exactly SCRAMBLE_LEN cycles, then IDLE. On entry: history cleared, move_count=0, scrambled=1.
- APPLY (1 cycle): engine driven from face_sel/rot_sel.
  - rot_sel==0 or face_sel>5: no-op; no push, no count.
  - Otherwise: cube_state<=eng_state_in; push {face,rot} at wr_ptr; wr_ptr+1 mod depth; hist_level+1 saturating at HIST_DEPTH (full -> oldest entry overwritten); redo_level=0; move_count+1 saturating at CNT_MAX.
- UNDO (1 cycle): only when hist_level>0, otherwise IDLE with no change. Engine gets the entry at wr_ptr-1 with rot'=(4-rot) mod 4. cube_state updates; wr_ptr-1; hist_level-1; redo_level+1; move_count-1 floored at 0.
- REDO: see Optional Feature.
- eng_face/eng_rot outside SCRAMBLE/APPLY/UNDO/REDO: face 0, rot 0.
- DONE: solved=1, busy=0. scramble_req -> SCRAMBLE (solved drops the next cycle). All other requests are ignored.
- Reset asserted mid-scramble or mid-move aborts immediately to reset values.

Optional Feature:
CUBE_REDO_EN.
- Defined: from IDLE, redo_req with redo_level>0 enters REDO (1 cycle). Re-apply the entry at wr_ptr; wr_ptr+1; hist_level+1; redo_level-1; move_count+1 saturating at CNT_MAX.
- Undefined: redo_req is ignored, REDO is unreachable, redo_level is absent.

Test Plan:
- Reset then 2 idle cycles -> cube_state=solved pattern, fsm_state=1, move_count=0, solved=0.
- Manual face 2 rot 1, then undo -> cube_state returns to solved; move_count 1 then 0; remains IDLE (scrambled=0, count 0).
- Scramble with SCRAMBLE_LEN=20 -> busy high exactly 20 cycles; move_count=0; hist_level=0.
- 70 manual moves with HIST_DEPTH=64 -> hist_level=64; 64 undos succeed; 65th undo is a no-op; move_count=6.
- Scramble; apply inverse moves until solved -> fsm_state=6, solved=1; move_req ignored; scramble_req leaves DONE.
- CUBE_REDO_EN: 3 moves, 2 undos, 2 redos -> state equals post-3-move state, move_count=3. New move after an undo -> redo_req ignored.

Source files
------------

// File: rtl/cube_session_ctrl.sv
// rtl/cube_session_ctrl.sv - cube session sequencer: start, scramble, manual move, undo and redo with solved detection
// Optional redo support is compiled in when CUBE_REDO_EN is defined.
module cube_session_ctrl #(
    parameter int STATE_W      = 162,
    parameter int HIST_DEPTH   = 64,
    parameter int SCRAMBLE_LEN = 20,
    parameter int CNT_W        = 10,
    parameter int CNT_MAX      = 999
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scramble_req,
    input  logic                          move_req,
    input  logic                          undo_req,
    input  logic                          redo_req,
    input  logic [2:0]                    face_sel,
    input  logic [1:0]                    rot_sel,
    input  logic [2:0]                    rand_face,
    input  logic [1:0]                    rand_rot,
    output logic [2:0]                    eng_face,
    output logic [2:0]                    eng_rot,
    input  logic [STATE_W-1:0]            eng_state_in,
    output logic [STATE_W-1:0]            cube_state,
    output logic [CNT_W-1:0]              move_count,
    output logic [$clog2(HIST_DEPTH):0]   hist_level,
    output logic                          busy,
    output logic                          solved,
    output logic [2:0]                    fsm_state
);
    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int SCR_W = (SCRAMBLE_LEN > 1) ? $clog2(SCRAMBLE_LEN) : 1;

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_IDLE     = 3'd1,
        S_SCRAMBLE = 3'd2,
        S_APPLY    = 3'd3,
        S_UNDO     = 3'd4,
        S_REDO     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] solved_pat;
    logic [PTR_W-1:0]   wr_ptr;
    logic               scrambled;
    logic [SCR_W-1:0]   scr_cnt;
    logic [4:0]         hist_mem [HIST_DEPTH];
    logic [4:0]         undo_entry;
    logic               move_ok;
    logic               at_solved;

`ifdef CUBE_REDO_EN
    logic [LVL_W-1:0]   redo_level;
    logic [4:0]         redo_entry;
    assign redo_entry = hist_mem[wr_ptr];
`else
    logic               unused_redo_req;
    assign unused_redo_req = redo_req;
`endif

    // Sticker s occupies bits [3s+2:3s]; face f owns stickers 9f..9f+8.
    always_comb begin
        solved_pat = '0;
        for (int i = 0; i < 54; i++) begin
            solved_pat[3*i +: 3] = 3'(i / 9);
        end
    end

    assign undo_entry = hist_mem[wr_ptr - PTR_W'(1)];
    assign move_ok    = (rot_sel != 2'd0) && (face_sel <= 3'd5);
    assign at_solved  = (cube_state == solved_pat) && ((move_count != '0) || scrambled);
    assign fsm_state  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_IDLE;
            S_IDLE: begin
                if (scramble_req) begin
                    state_d = S_SCRAMBLE;
                end else if (move_req) begin
                    state_d = S_APPLY;
                end else if (undo_req) begin
                    if (hist_level != '0) state_d = S_UNDO;
`ifdef CUBE_REDO_EN
                end else if (redo_req) begin
                    if (redo_level != '0) state_d = S_REDO;
`endif
                end else if (at_solved) begin
                    state_d = S_DONE;
                end
            end
            S_SCRAMBLE: if (scr_cnt == SCR_W'(SCRAMBLE_LEN - 1)) state_d = S_IDLE;
            S_APPLY:    state_d = S_IDLE;
            S_UNDO:     state_d = S_IDLE;
            S_REDO:     state_d = S_IDLE;
            S_DONE:     if (scramble_req) state_d = S_SCRAMBLE;
            default:    state_d = S_START;
        endcase
    end

    always_comb begin
        eng_face = 3'd0;
        eng_rot  = 3'd0;
        busy     = 1'b1;
        solved   = 1'b0;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_DONE: begin
                busy   = 1'b0;
                solved = 1'b1;
            end
            S_SCRAMBLE: begin
                eng_face = rand_face;
                case (rand_rot)
                    2'd1:    eng_rot = 3'd3;
                    2'd2:    eng_rot = 3'd2;
                    default: eng_rot = 3'd1;
                endcase
            end
            S_APPLY: begin
                eng_face = face_sel;
                eng_rot  = {1'b0, rot_sel};
            end
            S_UNDO: begin
                eng_face = undo_entry[4:2];
                eng_rot  = {1'b0, 2'd0 - undo_entry[1:0]};
            end
`ifdef CUBE_REDO_EN
            S_REDO: begin
                eng_face = redo_entry[4:2];
                eng_rot  = {1'b0, redo_entry[1:0]};
            end
`endif
            default: ;
        endcase
    end

    // History holds move codes only; undo replays the inverse rotation.
    always_ff @(posedge clk) begin
        if (state_q == S_APPLY && move_ok) begin
            hist_mem[wr_ptr] <= {face_sel, rot_sel};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cube_state <= '0;
            move_count <= '0;
            hist_level <= '0;
            wr_ptr     <= '0;
            scrambled  <= 1'b0;
            scr_cnt    <= '0;
`ifdef CUBE_REDO_EN
            redo_level <= '0;
`endif
        end else begin
            case (state_q)
                S_START: begin
                    cube_state <= solved_pat;
                    move_count <= '0;
                    hist_level <= '0;
                    wr_ptr     <= '0;
                    scrambled  <= 1'b0;
                    scr_cnt    <= '0;
`ifdef CUBE_REDO_EN
                    redo_level <= '0;
`endif
                end
                S_IDLE, S_DONE: begin
                    if (state_d == S_SCRAMBLE) begin
                        move_count <= '0;
                        hist_level <= '0;
                        wr_ptr     <= '0;
                        scrambled  <= 1'b1;
                        scr_cnt    <= '0;
`ifdef CUBE_REDO_EN
                        redo_level <= '0;
`endif
                    end
                end
                S_SCRAMBLE: begin
                    cube_state <= eng_state_in;
                    scr_cnt    <= scr_cnt + SCR_W'(1);
                end
                S_APPLY: begin
                    if (move_ok) begin
                        cube_state <= eng_state_in;
                        wr_ptr     <= wr_ptr + PTR_W'(1);
                        if (hist_level != LVL_W'(HIST_DEPTH)) hist_level <= hist_level + LVL_W'(1);
                        if (move_count != CNT_W'(CNT_MAX)) move_count <= move_count + CNT_W'(1);
`ifdef CUBE_REDO_EN
                        redo_level <= '0;
`endif
                    end
                end
                S_UNDO: begin
                    cube_state <= eng_state_in;
                    wr_ptr     <= wr_ptr - PTR_W'(1);
                    hist_level <= hist_level - LVL_W'(1);
                    if (move_count != '0) move_count <= move_count - CNT_W'(1);
`ifdef CUBE_REDO_EN
                    redo_level <= redo_level + LVL_W'(1);
`endif
                end
`ifdef CUBE_REDO_EN
                S_REDO: begin
                    cube_state <= eng_state_in;
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                    redo_level <= redo_level - LVL_W'(1);
                    if (hist_level != LVL_W'(HIST_DEPTH)) hist_level <= hist_level + LVL_W'(1);
                    if (move_count != CNT_W'(CNT_MAX)) move_count <= move_count + CNT_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cube_session_ctrl.sv
// tb/tb_cube_session_ctrl.sv - scoreboard bench for cube_session_ctrl with a strip-cycling engine model
module tb_cube_session_ctrl;
    localparam int SW    = 162;
    localparam int DEPTH = 64;
    localparam int SLEN  = 20;
    localparam int CMAX  = 999;

    typedef struct {
        string           name;
        logic [SW-1:0]   cube;
        int              cnt;
        int              lvl;
        int              fsm;
        int              sol;
        int              bsy;
        int              run;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          scramble_req, move_req, undo_req, redo_req;
    logic [2:0]    face_sel, rand_face, eng_face, eng_rot, fsm_state;
    logic [1:0]    rot_sel, rand_rot;
    logic [SW-1:0] eng_state_in, cube_state;
    logic [9:0]    move_count;
    logic [6:0]    hist_level;
    logic          busy, solved;

    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            run_cur = 0;
    int            last_run = 0;

    logic [SW-1:0] solved_c;
    logic [SW-1:0] m_cube;
    int            m_cnt;
    logic          m_scr;
    logic [SW-1:0] m_hist[$];
    logic [SW-1:0] m_redo[$];
    logic [2:0]    scr_f [SLEN];
    logic [1:0]    scr_r [SLEN];

    cube_session_ctrl dut (
        .clk(clk), .rst(rst),
        .scramble_req(scramble_req), .move_req(move_req), .undo_req(undo_req), .redo_req(redo_req),
        .face_sel(face_sel), .rot_sel(rot_sel), .rand_face(rand_face), .rand_rot(rand_rot),
        .eng_face(eng_face), .eng_rot(eng_rot), .eng_state_in(eng_state_in),
        .cube_state(cube_state), .move_count(move_count), .hist_level(hist_level),
        .busy(busy), .solved(solved), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Each quarter turn of face f cycles a 3-sticker strip around faces f+1..f+4.
    function automatic logic [SW-1:0] eng_model(input logic [SW-1:0] st, input logic [2:0] f, input logic [2:0] q);
        logic [SW-1:0] r, t;
        int src, dst, off;
        r = st;
        off = 3 * (int'(f) % 3);
        for (int k = 0; k < int'(q); k++) begin
            t = r;
            for (int j = 0; j < 4; j++) begin
                src = (int'(f) + 1 + j) % 6;
                dst = (int'(f) + 1 + (j + 1) % 4) % 6;
                for (int p = 0; p < 3; p++)
                    t[3*(9*dst + off + p) +: 3] = r[3*(9*src + off + p) +: 3];
            end
            r = t;
        end
        return r;
    endfunction

    always_comb eng_state_in = eng_model(cube_state, eng_face, eng_rot);

    function automatic logic [2:0] rmap(input logic [1:0] r);
        case (r)
            2'd1:    return 3'd3;
            2'd2:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic int settle_target();
        return (m_cube == solved_c && (m_cnt != 0 || m_scr)) ? 6 : 1;
    endfunction

    function automatic logic [1:0] pick_rot(input logic [2:0] f);
        return (eng_model(m_cube, f, 3'd1) == solved_c) ? 2'd2 : 2'd1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) run_cur++;
        else begin
            if (run_cur > 0) last_run = run_cur;
            run_cur = 0;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (cube_state === e.cube) n_pass++;
            else $display("FAIL %s.cube: got %h, expected %h", e.name, cube_state, e.cube);
            chk({e.name, ".move_count"}, int'(move_count), e.cnt);
            chk({e.name, ".hist_level"}, int'(hist_level), e.lvl);
            chk({e.name, ".fsm_state"}, int'(fsm_state), e.fsm);
            chk({e.name, ".solved"}, int'(solved), e.sol);
            chk({e.name, ".busy"}, int'(busy), e.bsy);
            if (e.run >= 0) chk({e.name, ".busy_run"}, last_run, e.run);
        end
    end

    task automatic push(input string nm, input int fsm, input int sol, input int bsy, input int run);
        exp_t e;
        #1;
        e.name = nm; e.cube = m_cube; e.cnt = m_cnt; e.lvl = m_hist.size();
        e.fsm = fsm; e.sol = sol; e.bsy = bsy; e.run = run;
        exp_q.push_back(e);
    endtask

    task automatic settle(input int target);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (int'(fsm_state) == target) break;
        end
        if (k == 100) begin
            n_chk++;
            $display("FAIL settle: fsm_state=%0d, expected %0d within 100 cycles", fsm_state, target);
        end
    endtask

    task automatic do_move(input logic [2:0] f, input logic [1:0] r);
        @(negedge clk); face_sel = f; rot_sel = r; move_req = 1'b1;
        @(posedge clk); #1 move_req = 1'b0;
        if (r != 2'd0 && f <= 3'd5) begin
            m_hist.push_back(m_cube);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            m_cube = eng_model(m_cube, f, {1'b0, r});
            if (m_cnt < CMAX) m_cnt++;
            m_redo.delete();
        end
        settle(settle_target());
    endtask

    task automatic do_undo();
        @(negedge clk); undo_req = 1'b1;
        @(posedge clk); #1 undo_req = 1'b0;
        if (m_hist.size() > 0) begin
            m_redo.push_back(m_cube);
            m_cube = m_hist.pop_back();
            if (m_cnt > 0) m_cnt--;
        end
        settle(settle_target());
    endtask

    task automatic do_redo();
        @(negedge clk); redo_req = 1'b1;
        @(posedge clk); #1 redo_req = 1'b0;
`ifdef CUBE_REDO_EN
        if (m_redo.size() > 0) begin
            m_hist.push_back(m_cube);
            m_cube = m_redo.pop_back();
            if (m_cnt < CMAX) m_cnt++;
        end
`endif
        settle(settle_target());
    endtask

    task automatic do_scramble(input bit chk_entry);
        @(negedge clk); scramble_req = 1'b1;
        @(posedge clk); #1 scramble_req = 1'b0;
        m_hist.delete(); m_redo.delete(); m_cnt = 0; m_scr = 1'b1;
        if (chk_entry) push("scramble_entry", 2, 0, 1, -1);
        for (int i = 0; i < SLEN; i++) begin
            rand_face = scr_f[i]; rand_rot = scr_r[i];
            m_cube = eng_model(m_cube, scr_f[i], rmap(scr_r[i]));
            @(posedge clk); #1;
        end
        settle(settle_target());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic [2:0] f;
        rst = 1'b0; scramble_req = 0; move_req = 0; undo_req = 0; redo_req = 0;
        face_sel = 0; rot_sel = 0; rand_face = 0; rand_rot = 0;
        solved_c = '0;
        for (int i = 0; i < 54; i++) solved_c[3*i +: 3] = 3'(i / 9);
        for (int i = 0; i < SLEN; i++) begin
            scr_f[i] = 3'((i * 5) % 6);
            scr_r[i] = 2'(i % 4);
        end
        m_cube = '0; m_cnt = 0; m_scr = 1'b0;

        push("reset", 0, 0, 1, -1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_cube = solved_c;
        repeat (2) @(negedge clk);
        push("after_reset", 1, 0, 0, -1);

        do_move(3'd2, 2'd1);
        push("move_f2_cw", 1, 0, 0, -1);
        do_undo();
        repeat (3) @(negedge clk);
        push("undo_back_to_solved", 1, 0, 0, -1);
        do_move(3'd1, 2'd0);
        do_move(3'd6, 2'd1);
        do_undo();
        push("noop_moves_and_empty_undo", 1, 0, 0, -1);

        do_scramble(1'b0);
        push("scramble", 1, 0, 0, SLEN);

        for (int k = SLEN - 1; k >= 0; k--) begin
            do_move(scr_f[k], 2'((4 - int'(rmap(scr_r[k]))) % 4));
            if (m_cube == solved_c) break;
        end
        push("solved_done", 6, 1, 0, -1);
        @(negedge clk); face_sel = 3'd0; rot_sel = 2'd1; move_req = 1'b1;
        @(posedge clk); #1 move_req = 1'b0;
        repeat (2) @(negedge clk);
        push("done_ignores_move", 6, 1, 0, -1);
        do_scramble(1'b1);
        push("rescramble_from_done", 1, 0, 0, -1);

        for (int i = 0; i < 70; i++) begin
            f = 3'(i % 6);
            r = pick_rot(f);
            do_move(f, r);
        end
        push("moves70", 1, 0, 0, -1);
        for (int i = 0; i < DEPTH; i++) begin
            do_undo();
            if (i == 0) push("undo_first", 1, 0, 0, -1);
        end
        push("undo64", 1, 0, 0, -1);
        do_undo();
        push("undo65_noop", 1, 0, 0, -1);

`ifdef CUBE_REDO_EN
        for (int i = 0; i < 3; i++) begin
            f = 3'((i + 2) % 6);
            r = pick_rot(f);
            do_move(f, r);
        end
        do_undo();
        do_undo();
        push("after_two_undos", 1, 0, 0, -1);
        do_redo();
        do_redo();
        push("redo_restores", 1, 0, 0, -1);
        do_undo();
        f = 3'd4;
        r = pick_rot(f);
        do_move(f, r);
        do_redo();
        push("redo_after_move_ignored", 1, 0, 0, -1);
`else
        do_redo();
        push("redo_ignored", 1, 0, 0, -1);
`endif

        @(negedge clk); scramble_req = 1'b1;
        @(posedge clk); #1 scramble_req = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        m_cube = '0; m_cnt = 0; m_hist.delete(); m_redo.delete();
        push("reset_mid_scramble", 0, 0, 1, -1);

        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
